// File: rtl/dtfag_pkg.sv
// Shared types and constants for the radix-16 DTFAG twiddle address generator.
package dtfag_pkg;

    localparam int RADIX          = 16;
    localparam int PAIRS_PER_BFLY = 8;

    // Tag fields are sized for the largest supported transform (N_LOG up to 32);
    // the top level zero-extends into them and truncates back out.
    localparam int TAG_STAGE_W = 4;
    localparam int TAG_BFLY_W  = 28;
    localparam int TAG_PAIR_W  = 3;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} dtfag_state_e;

    typedef struct packed {
        logic [TAG_STAGE_W-1:0] stage;
        logic [TAG_BFLY_W-1:0]  bfly;
        logic [TAG_PAIR_W-1:0]  pair;
    } dtfag_tag_t;

endpackage

// File: rtl/dtfag_valid_delay.sv
// ROM_LAT-deep shift register carrying {valid, tag} so they line up with ROM read data.
// pend_o reports a valid anywhere except the output stage, so the owner can tell
// that the line will be empty after the current tail drains.
module dtfag_valid_delay
    import dtfag_pkg::*;
#(
    parameter int LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       en_i,
    input  logic       vld_i,
    input  dtfag_tag_t tag_i,
    output logic       vld_o,
    output dtfag_tag_t tag_o,
    output logic       pend_o
);

    logic [LAT-1:0] vld_q;
    dtfag_tag_t     tag_q [LAT];

    // Shift one position per enabled cycle; frozen when en_i is low.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            vld_q <= '0;
            for (int i = 0; i < LAT; i++) tag_q[i] <= '0;
        end else if (en_i) begin
            vld_q[0] <= vld_i;
            tag_q[0] <= tag_i;
            for (int i = 1; i < LAT; i++) begin
                vld_q[i] <= vld_q[i-1];
                tag_q[i] <= tag_q[i-1];
            end
        end
    end

    // Any valid still short of the output stage.
    always_comb begin
        pend_o = 1'b0;
        for (int i = 0; i < LAT - 1; i++) pend_o = pend_o | vld_q[i];
    end

    assign vld_o = vld_q[LAT-1];
    assign tag_o = tag_q[LAT-1];

endmodule

// File: rtl/dtfag_rom_addr_gen.sv
// Twiddle-exponent / ROM-address generator for the radix-16 DTFAG.
// Walks stage / butterfly / lane-pair and emits two exponents per cycle, split
// into HA/LA ROM addresses, with valid and tag delayed to meet the ROM data.
// Build option: DTFAG_STALL_EN makes stall_i freeze the whole generator;
// without it stall_i is ignored.
module dtfag_rom_addr_gen
    import dtfag_pkg::*;
#(
    parameter  int N_LOG   = 16,
    parameter  int ROM_LAT = 1,
    localparam int STAGES  = N_LOG / 4,
    localparam int AW      = N_LOG / 2,
    localparam int SW      = $clog2(STAGES),
    localparam int BW      = N_LOG - 4
) (
    input  logic          clk_i,
    input  logic          rst_n_i,
    input  logic          start_i,
    input  logic          stall_i,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] b0_ha_addr_o,
    output logic [AW-1:0] b0_la_addr_o,
    output logic [AW-1:0] b1_ha_addr_o,
    output logic [AW-1:0] b1_la_addr_o,
    output logic          rom_valid_o,
    output logic [SW-1:0] tag_stage_o,
    output logic [BW-1:0] tag_bfly_o,
    output logic [2:0]    tag_k_o
);

    localparam int DIG = $clog2(RADIX);
    localparam int PW  = $clog2(PAIRS_PER_BFLY);

    dtfag_state_e   state_q, state_d;
    logic [SW-1:0]  stage_q, stage_d;
    logic [BW-1:0]  bfly_q, bfly_d;
    logic [PW-1:0]  pair_q, pair_d;
    logic [N_LOG-1:0] e0_q, e0_d, e1_q, e1_d;
    logic [N_LOG-1:0] base_cur, step;
    logic           last_pair;
    logic           stall_act;
    logic           issue;
    logic           addr_vld_q;
    dtfag_tag_t     cur_tag, addr_tag_q, dly_tag;
    logic           dly_vld, dly_pend;
    logic [AW-1:0]  b0_ha_q, b0_la_q, b1_ha_q, b1_la_q;
    logic           unused_tag;

`ifdef DTFAG_STALL_EN
    assign stall_act = stall_i;
`else
    logic unused_stall;
    assign unused_stall = stall_i;
    assign stall_act    = 1'b0;
`endif

    // base = (b mod 16^s) << 4*(STAGES-1-s); stage 0 always yields 0.
    function automatic logic [N_LOG-1:0] calc_base(input logic [SW-1:0] s, input logic [BW-1:0] b);
        logic [N_LOG-1:0] mask;
        mask = (N_LOG'(1) << (DIG * s)) - N_LOG'(1);
        return (N_LOG'(b) & mask) << (DIG * (STAGES - 1 - int'(s)));
    endfunction

    assign base_cur = calc_base(stage_q, bfly_q);
    assign step     = {base_cur[N_LOG-2:0], 1'b0};
    assign issue    = (state_q == RUN);
    assign cur_tag  = '{stage: TAG_STAGE_W'(stage_q), bfly: TAG_BFLY_W'(bfly_q), pair: TAG_PAIR_W'(pair_q)};

    // Loop counters and exponent accumulators: pair innermost, then butterfly, then stage.
    always_comb begin
        stage_d   = stage_q;
        bfly_d    = bfly_q;
        pair_d    = pair_q;
        e0_d      = e0_q;
        e1_d      = e1_q;
        last_pair = 1'b0;
        if (issue && !stall_act) begin
            if (pair_q == PW'(PAIRS_PER_BFLY - 1)) begin
                pair_d = '0;
                if (bfly_q == {BW{1'b1}}) begin
                    bfly_d = '0;
                    if (stage_q == SW'(STAGES - 1)) begin
                        stage_d   = '0;
                        last_pair = 1'b1;
                    end else begin
                        stage_d = stage_q + 1'b1;
                    end
                end else begin
                    bfly_d = bfly_q + 1'b1;
                end
                // New butterfly restarts at e0 = 0, e1 = base of that butterfly.
                e0_d = '0;
                e1_d = calc_base(stage_d, bfly_d);
            end else begin
                pair_d = pair_q + 1'b1;
                e0_d   = e0_q + step;
                e1_d   = e1_q + step;
            end
        end
    end

    // Sweep sequencing; DRAIN waits until only the delay-line tail can still be valid.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (last_pair) state_d = DRAIN;
            DRAIN:   if (!stall_act && !addr_vld_q && !dly_pend) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // FSM, counter and accumulator registers.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= IDLE;
            stage_q <= '0;
            bfly_q  <= '0;
            pair_q  <= '0;
            e0_q    <= '0;
            e1_q    <= '0;
        end else begin
            state_q <= state_d;
            stage_q <= stage_d;
            bfly_q  <= bfly_d;
            pair_q  <= pair_d;
            e0_q    <= e0_d;
            e1_q    <= e1_d;
        end
    end

    // Registered ROM addresses plus the valid/tag that travel with them; hold outside RUN.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            addr_vld_q <= 1'b0;
            addr_tag_q <= '0;
            b0_ha_q    <= '0;
            b0_la_q    <= '0;
            b1_ha_q    <= '0;
            b1_la_q    <= '0;
        end else if (!stall_act) begin
            addr_vld_q <= issue;
            if (issue) begin
                addr_tag_q <= cur_tag;
                b0_ha_q    <= e0_q[N_LOG-1:AW];
                b0_la_q    <= e0_q[AW-1:0];
                b1_ha_q    <= e1_q[N_LOG-1:AW];
                b1_la_q    <= e1_q[AW-1:0];
            end
        end
    end

    dtfag_valid_delay #(.LAT(ROM_LAT)) u_valid_delay (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .en_i    (!stall_act),
        .vld_i   (addr_vld_q),
        .tag_i   (addr_tag_q),
        .vld_o   (dly_vld),
        .tag_o   (dly_tag),
        .pend_o  (dly_pend)
    );

    assign busy_o       = (state_q == RUN) || (state_q == DRAIN);
    assign done_o       = (state_q == DONE);
    assign b0_ha_addr_o = b0_ha_q;
    assign b0_la_addr_o = b0_la_q;
    assign b1_ha_addr_o = b1_ha_q;
    assign b1_la_addr_o = b1_la_q;
    assign rom_valid_o  = dly_vld && !stall_act;
    assign tag_stage_o  = dly_tag.stage[SW-1:0];
    assign tag_bfly_o   = dly_tag.bfly[BW-1:0];
    assign tag_k_o      = dly_tag.pair;
    assign unused_tag   = ^dly_tag;

endmodule
